tpu_run_controller: RTL and testbench
=====================================

Name: tpu_run_controller

Overview:
- Owns the 64x8 program memory of the tekito processing unit and shares it between the CPU fetch port and a host load/debug port.
- Sequences the core: hold, restart, free-run, run-N-instructions, and breakpoint halt.
- Sits between the host interface and the core. It drives the core's MEMORY_DATA and RESET, plus a clock-enable consumed by the core's clock-enable wrapper.

Parameters:
- ADDR_W, 6, program address width (memory depth 2**ADDR_W)
- DATA_W, 8, instruction width
- CNT_W, 8, step-budget counter width

Ports:
- CLOCK  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous, active-low controller reset
- HOST_VALID  in  1  host command strobe
- HOST_READY  out  1  command accepted when HOST_VALID & HOST_READY
- HOST_CMD  in  2  00 WRITE, 01 READ, 10 RUN, 11 HALT
- HOST_ADDR  in  ADDR_W  memory address (WRITE/READ); bit0 = restart request (RUN)
- HOST_WDATA  in  DATA_W  write data (WRITE); step budget N (RUN), 0 = free-run
- HOST_RDATA  out  DATA_W  read data
- HOST_RVALID  out  1  one-cycle pulse, HOST_RDATA valid
- HOST_ERR  out  1  one-cycle pulse, command rejected
- BP_EN  in  1  breakpoint enable
- BP_ADDR  in  ADDR_W  breakpoint address
- CPU_ADDR  in  ADDR_W  core fetch address (core MEMORY_ADDR)
- CPU_DATA  out  DATA_W  instruction to core, combinational mem[CPU_ADDR]
- CPU_RESET  out  1  active-low reset to core
- CPU_CE  out  1  core clock enable
- STATE  out  2  0 HALT, 1 RESTART, 2 RUN
- BP_HIT  out  1  sticky breakpoint-halt flag

Behaviour:
- Reset (RESET=0, async):
  - STATE=HALT; all 64 memory words=8'h00.
  - CPU_RESET=0 while RESET=0, 1 after release.
  - CPU_CE=0, HOST_RDATA=0, HOST_RVALID=0, HOST_ERR=0, BP_HIT=0, budget counter=0, free-run flag=0.
  - HOST_READY=1 after release.
- HOST_READY:
  - =1 in HALT and RUN.
  - =0 in RESTART (one cycle only).
- HALT state, CPU_CE=0:
  - WRITE: mem[HOST_ADDR]<=HOST_WDATA at the edge. CPU_DATA reflects the new value from the next cycle if CPU_ADDR matches.
  - READ: HOST_RDATA<=mem[HOST_ADDR] and HOST_RVALID=1 for exactly the next cycle. Latency 1.
  - RUN:
    - budget<=HOST_WDATA; free-run flag=(HOST_WDATA==0); BP_HIT<=0.
    - If HOST_ADDR[0]=1, go to RESTART, else go to RUN.
  - HALT: no-op, no error.
- RESTART: CPU_RESET=0 and CPU_CE=0 for exactly one cycle, then RUN unconditionally.
- RUN state, CPU_CE=1 except on a breakpoint cycle:
  - Each CE cycle decrements the budget when not free-run.
  - A CE cycle with budget==1 is the last one; next state HALT.
  - N instructions execute exactly N CE cycles.
- Breakpoint: in RUN, if BP_EN and CPU_ADDR==BP_ADDR:
  - CPU_CE=0 that cycle; next state HALT; BP_HIT<=1.
  - Budget is unchanged.
  - Ignored on the first RUN cycle after entry, so a RUN from a breakpoint address makes progress.
- Command rejection:
  - HALT command in RUN: next state HALT; the current cycle's CE still counts.
  - WRITE or READ in RUN: rejected with HOST_ERR pulse next cycle; memory unchanged, no RVALID.
  - RUN in RUN: rejected with HOST_ERR.
- Simultaneous events: HALT command, budget expiry and breakpoint in the same cycle → HALT, no HOST_ERR. Breakpoint has priority for CE (CE=0) and for BP_HIT.
- Budget arithmetic: unsigned CNT_W bits, never wraps. Free-run never decrements.
- Async reset mid-RUN:
  - Immediately forces CPU_CE=0 and CPU_RESET=0.
  - Clears memory; no partial write survives.

Test Plan:
- Reset, then WRITE 0x05→addr 3, then READ addr 3 → HOST_RVALID one cycle later with HOST_RDATA=0x05; READ addr 4 → 0x00.
- Load program, RUN with HOST_ADDR[0]=1, N=4 → STATE=RESTART one cycle with CPU_RESET=0, then exactly 4 cycles of CPU_CE=1, then STATE=HALT.
- RUN N=0, then HALT after 10 cycles → CE high for 10 cycles then 0, no HOST_ERR.
- BP_EN=1, BP_ADDR=6, free-run, core reaches addr 6 → CE=0 that cycle, BP_HIT=1, HALT. Second RUN N=1 → one CE cycle at addr 6, BP_HIT cleared.
- During RUN issue WRITE addr 0 data 0xFF → HOST_ERR pulse, a later READ addr 0 returns original data. RUN in RUN → HOST_ERR.
- Assert RESET mid-RUN for 2 cycles → CPU_CE=0 and CPU_RESET=0 immediately, STATE=HALT, all READs return 0x00.

Source files
------------

// File: rtl/tpu_run_controller.sv
// Run controller for the tekito processing unit: owns the program memory,
// arbitrates it between core fetch and host load/debug, and sequences the core.
module tpu_run_controller #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              HOST_VALID,
  output logic              HOST_READY,
  input  logic [1:0]        HOST_CMD,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [DATA_W-1:0] HOST_WDATA,
  output logic [DATA_W-1:0] HOST_RDATA,
  output logic              HOST_RVALID,
  output logic              HOST_ERR,
  input  logic              BP_EN,
  input  logic [ADDR_W-1:0] BP_ADDR,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  output logic [DATA_W-1:0] CPU_DATA,
  output logic              CPU_RESET,
  output logic              CPU_CE,
  output logic [1:0]        STATE,
  output logic              BP_HIT
);

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_RUN   = 2'b10;
  localparam logic [1:0] CMD_HALT  = 2'b11;
  localparam int         DEPTH     = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_HALT    = 2'd0,
    S_RESTART = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  budget;
  logic              free_run;
  logic              first_run;
  logic              accept;
  logic              bp_now;
  logic              ce;
  logic              last_step;
  logic              do_write;
  logic              do_read;
  logic              start_run;
  logic              reject;

  always_comb begin
    HOST_READY = RESET && (state != S_RESTART);
    accept     = HOST_VALID && HOST_READY;
    // The first RUN cycle ignores the breakpoint so a resume from the breakpoint address advances.
    bp_now     = (state == S_RUN) && BP_EN && (CPU_ADDR == BP_ADDR) && !first_run;
    ce         = (state == S_RUN) && !bp_now;
    last_step  = ce && !free_run && (budget == CNT_W'(1));
    do_write   = accept && (state == S_HALT) && (HOST_CMD == CMD_WRITE);
    do_read    = accept && (state == S_HALT) && (HOST_CMD == CMD_READ);
    start_run  = accept && (state == S_HALT) && (HOST_CMD == CMD_RUN);
    reject     = accept && (state == S_RUN) && (HOST_CMD != CMD_HALT);
    state_next = state;
    case (state)
      S_HALT: begin
        if (start_run) begin
          state_next = HOST_ADDR[0] ? S_RESTART : S_RUN;
        end
      end
      S_RESTART: state_next = S_RUN;
      S_RUN: begin
        if (bp_now || last_step || (accept && (HOST_CMD == CMD_HALT))) begin
          state_next = S_HALT;
        end
      end
      default: state_next = S_HALT;
    endcase
  end

  assign CPU_RESET = RESET && (state != S_RESTART);
  assign CPU_CE    = ce;
  assign STATE     = state;
  assign CPU_DATA  = mem[CPU_ADDR];

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= S_HALT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[HOST_ADDR] <= HOST_WDATA;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      HOST_RDATA  <= '0;
      HOST_RVALID <= 1'b0;
      HOST_ERR    <= 1'b0;
      BP_HIT      <= 1'b0;
      budget      <= '0;
      free_run    <= 1'b0;
      first_run   <= 1'b0;
    end else begin
      HOST_RVALID <= do_read;
      HOST_ERR    <= reject;
      first_run   <= (state != S_RUN) && (state_next == S_RUN);
      if (do_read) begin
        HOST_RDATA <= mem[HOST_ADDR];
      end
      if (start_run) begin
        budget   <= CNT_W'(HOST_WDATA);
        free_run <= (HOST_WDATA == '0);
        BP_HIT   <= 1'b0;
      end else begin
        if (bp_now) begin
          BP_HIT <= 1'b1;
        end
        // Saturating countdown: a spent budget never wraps back to a large value.
        if (ce && !free_run && (budget != '0)) begin
          budget <= budget - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tpu_run_controller.sv
// Self-checking bench for tpu_run_controller: host reads are scoreboarded,
// run/breakpoint/reject behaviour is checked against a tiny core PC model.
module tb_tpu_run_controller;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_RUN   = 2'b10;
  localparam logic [1:0] CMD_HALT  = 2'b11;

  logic       CLOCK;
  logic       RESET;
  logic       HOST_VALID;
  logic       HOST_READY;
  logic [1:0] HOST_CMD;
  logic [5:0] HOST_ADDR;
  logic [7:0] HOST_WDATA;
  logic [7:0] HOST_RDATA;
  logic       HOST_RVALID;
  logic       HOST_ERR;
  logic       BP_EN;
  logic [5:0] BP_ADDR;
  logic [5:0] CPU_ADDR;
  logic [7:0] CPU_DATA;
  logic       CPU_RESET;
  logic       CPU_CE;
  logic [1:0] STATE;
  logic       BP_HIT;

  logic [5:0] pc;
  logic [7:0] exp_q[$];
  int         total_checks = 0;
  int         pass_checks  = 0;
  int         ce_count     = 0;
  int         err_count    = 0;
  int         exp_err      = 0;

  tpu_run_controller #(.ADDR_W(6), .DATA_W(8), .CNT_W(8)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .HOST_VALID (HOST_VALID),
    .HOST_READY (HOST_READY),
    .HOST_CMD   (HOST_CMD),
    .HOST_ADDR  (HOST_ADDR),
    .HOST_WDATA (HOST_WDATA),
    .HOST_RDATA (HOST_RDATA),
    .HOST_RVALID(HOST_RVALID),
    .HOST_ERR   (HOST_ERR),
    .BP_EN      (BP_EN),
    .BP_ADDR    (BP_ADDR),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_DATA   (CPU_DATA),
    .CPU_RESET  (CPU_RESET),
    .CPU_CE     (CPU_CE),
    .STATE      (STATE),
    .BP_HIT     (BP_HIT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Minimal core: the fetch address restarts at 0 and advances on each enabled cycle.
  always @(posedge CLOCK or negedge RESET) begin
    if (!RESET) pc <= '0;
    else if (!CPU_RESET) pc <= '0;
    else if (CPU_CE) pc <= pc + 6'd1;
  end
  assign CPU_ADDR = pc;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    else
      pass_checks++;
  endtask

  task automatic applyStimulus(input logic [1:0] cmd, input logic [5:0] addr, input logic [7:0] wdata);
    @(posedge CLOCK);
    #1;
    HOST_VALID = 1'b1;
    HOST_CMD   = cmd;
    HOST_ADDR  = addr;
    HOST_WDATA = wdata;
    @(posedge CLOCK);
    #1;
    HOST_VALID = 1'b0;
  endtask

  task automatic hostRead(input logic [5:0] addr, input logic [7:0] expected);
    exp_q.push_back(expected);
    applyStimulus(CMD_READ, addr, 8'h00);
  endtask

  task automatic waitHalt(input int limit, output int ces);
    ces = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLOCK);
      if (STATE == 2'd0) break;
      if (CPU_CE) ces++;
    end
  endtask

  // Scoreboard side: every read-data pulse must match the oldest expected value.
  always @(negedge CLOCK) begin
    if (RESET) begin
      if (CPU_CE) ce_count++;
      if (HOST_ERR) err_count++;
      if (HOST_RVALID) begin
        if (exp_q.size() == 0) checkOutput("rvalid_unexpected", 32'd1, 32'd0);
        else checkOutput("rdata", {24'd0, HOST_RDATA}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int snap_ce;
    int snap_err;
    logic [5:0] snap_pc;
    RESET      = 1'b1;
    HOST_VALID = 1'b0;
    HOST_CMD   = CMD_HALT;
    HOST_ADDR  = '0;
    HOST_WDATA = '0;
    BP_EN      = 1'b0;
    BP_ADDR    = '0;
    #1 RESET = 1'b0;
    #3;
    checkOutput("rst_state", STATE, 2'd0);
    checkOutput("rst_cpu_reset", CPU_RESET, 1'b0);
    checkOutput("rst_ce", CPU_CE, 1'b0);
    checkOutput("rst_rvalid", HOST_RVALID, 1'b0);
    checkOutput("rst_err", HOST_ERR, 1'b0);
    checkOutput("rst_bp_hit", BP_HIT, 1'b0);
    checkOutput("rst_rdata", HOST_RDATA, 8'h00);
    @(posedge CLOCK);
    #2 RESET = 1'b1;
    #1;
    checkOutput("rel_ready", HOST_READY, 1'b1);
    checkOutput("rel_cpu_reset", CPU_RESET, 1'b1);

    $display("[TB] write/read basics");
    applyStimulus(CMD_WRITE, 6'd3, 8'h05);
    hostRead(6'd3, 8'h05);
    @(negedge CLOCK);
    checkOutput("read_latency", HOST_RVALID, 1'b1);
    hostRead(6'd4, 8'h00);

    $display("[TB] restart run N=4");
    for (int i = 0; i < 8; i++) applyStimulus(CMD_WRITE, 6'(i), 8'h10 + 8'(i));
    @(negedge CLOCK);
    checkOutput("cpu_data_comb", CPU_DATA, 8'h10);
    applyStimulus(CMD_RUN, 6'd1, 8'd4);
    @(negedge CLOCK);
    checkOutput("restart_state", STATE, 2'd1);
    checkOutput("restart_cpu_reset", CPU_RESET, 1'b0);
    checkOutput("restart_ce", CPU_CE, 1'b0);
    checkOutput("restart_ready", HOST_READY, 1'b0);
    waitHalt(20, n);
    checkOutput("run4_halted", STATE, 2'd0);
    checkOutput("run4_ce_cycles", n, 4);
    checkOutput("run4_pc", pc, 6'd4);

    $display("[TB] free-run halted by host");
    snap_err = err_count;
    applyStimulus(CMD_RUN, 6'd0, 8'd0);
    snap_ce = ce_count;
    repeat (8) @(posedge CLOCK);
    applyStimulus(CMD_HALT, 6'd0, 8'd0);
    repeat (2) @(negedge CLOCK);
    #1;
    checkOutput("free_ce_cycles", ce_count - snap_ce, 10);
    checkOutput("free_halted", STATE, 2'd0);
    checkOutput("free_pc", pc, 6'd14);
    checkOutput("free_no_err", err_count - snap_err, 0);

    $display("[TB] breakpoint halt and resume");
    BP_EN   = 1'b1;
    BP_ADDR = 6'd6;
    applyStimulus(CMD_RUN, 6'd1, 8'd0);
    waitHalt(40, n);
    checkOutput("bp_halted", STATE, 2'd0);
    checkOutput("bp_ce_cycles", n, 6);
    checkOutput("bp_pc", pc, 6'd6);
    checkOutput("bp_hit_set", BP_HIT, 1'b1);
    applyStimulus(CMD_RUN, 6'd0, 8'd1);
    @(negedge CLOCK);
    checkOutput("bp_resume_ce", CPU_CE, 1'b1);
    checkOutput("bp_hit_cleared", BP_HIT, 1'b0);
    @(negedge CLOCK);
    checkOutput("bp_resume_halted", STATE, 2'd0);
    checkOutput("bp_resume_pc", pc, 6'd7);
    BP_EN = 1'b0;

    $display("[TB] rejected commands while running");
    applyStimulus(CMD_RUN, 6'd0, 8'd0);
    applyStimulus(CMD_WRITE, 6'd0, 8'hFF);
    exp_err++;
    @(negedge CLOCK);
    checkOutput("err_write", HOST_ERR, 1'b1);
    applyStimulus(CMD_READ, 6'd0, 8'h00);
    exp_err++;
    @(negedge CLOCK);
    checkOutput("err_read", HOST_ERR, 1'b1);
    applyStimulus(CMD_RUN, 6'd0, 8'd5);
    exp_err++;
    @(negedge CLOCK);
    checkOutput("err_run", HOST_ERR, 1'b1);
    checkOutput("err_run_state", STATE, 2'd2);
    applyStimulus(CMD_HALT, 6'd0, 8'd0);
    @(negedge CLOCK);
    checkOutput("halt_state", STATE, 2'd0);
    checkOutput("halt_no_err", HOST_ERR, 1'b0);
    hostRead(6'd0, 8'h10);

    $display("[TB] reset mid-run");
    applyStimulus(CMD_RUN, 6'd1, 8'd0);
    repeat (4) @(posedge CLOCK);
    #2 RESET = 1'b0;
    #1;
    checkOutput("mid_rst_ce", CPU_CE, 1'b0);
    checkOutput("mid_rst_cpu_reset", CPU_RESET, 1'b0);
    checkOutput("mid_rst_state", STATE, 2'd0);
    repeat (2) @(posedge CLOCK);
    #2 RESET = 1'b1;
    #1;
    checkOutput("mid_rst_cpu_data", CPU_DATA, 8'h00);
    hostRead(6'd0, 8'h00);
    hostRead(6'd3, 8'h00);
    hostRead(6'd7, 8'h00);

    repeat (3) @(negedge CLOCK);
    #1;
    checkOutput("sb_drain", exp_q.size(), 0);
    checkOutput("err_total", err_count, exp_err);
    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
